// File: rtl/arc4_init.sv
// arc4_init: fills the external S memory with the identity permutation
// S[i] = i, one write per clock, on an rdy/en start handshake.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | rdy=1, no writes, addr/wrdata parked at 0, waiting for en
// ST_FILL  | one write per cycle, addr/wrdata = 0..DEPTH-1 ascending
//
// Unused state encodings behave as ST_IDLE and return to it.
module arc4_init #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst_n,   // active-high synchronous reset
    input  logic              en,
    output logic              rdy,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wrdata,
    output logic              wren
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_FILL = 2'd1;

    // One extra bit so the count can reach DEPTH == 2**ADDR_W without wrapping.
    localparam logic [ADDR_W:0] CNT_END = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W + 1)'(1);

    logic [1:0]        state;
    logic [ADDR_W:0]   cnt;    // index of the next entry to be written
    logic [DATA_W-1:0] cnt_data;

    // Write data is the address zero-extended or truncated to DATA_W.
    generate
        if (DATA_W > ADDR_W) begin : g_data_ext
            assign cnt_data = {{(DATA_W - ADDR_W){1'b0}}, cnt[ADDR_W-1:0]};
        end else begin : g_data_trunc
            assign cnt_data = cnt[DATA_W-1:0];
        end
    endgenerate

    // Controller and registered S memory write port.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            rdy    <= 1'b1;
            wren   <= 1'b0;
            addr   <= '0;
            wrdata <= '0;
        end else begin
            case (state)
                ST_FILL: begin
                    if (cnt == CNT_END) begin
                        state  <= ST_IDLE;
                        cnt    <= '0;
                        rdy    <= 1'b1;
                        wren   <= 1'b0;
                        addr   <= '0;
                        wrdata <= '0;
                    end else begin
                        cnt    <= cnt + CNT_ONE;
                        rdy    <= 1'b0;
                        wren   <= 1'b1;
                        addr   <= cnt[ADDR_W-1:0];
                        wrdata <= cnt_data;
                    end
                end
                default: begin
                    // Entry 0 is written on the start edge itself, so the
                    // counter resumes from 1.
                    if (en) begin
                        state  <= ST_FILL;
                        cnt    <= CNT_ONE;
                        rdy    <= 1'b0;
                        wren   <= 1'b1;
                    end else begin
                        state  <= ST_IDLE;
                        cnt    <= '0;
                        rdy    <= 1'b1;
                        wren   <= 1'b0;
                    end
                    addr   <= '0;
                    wrdata <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_arc4_init.sv
// Bench for arc4_init: stimulus pushes the expected write sequence into a
// queue, a negedge monitor pops one entry per observed write.
module tb_arc4_init;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 256;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              en;
    logic              rdy;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wrdata;
    logic              wren;

    int checks = 0;
    int errors = 0;

    logic [ADDR_W-1:0] exp_q[$];

    arc4_init #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .rdy    (rdy),
        .addr   (addr),
        .wrdata (wrdata),
        .wren   (wren)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic push_fill(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(ADDR_W'(i));
    endtask

    // Monitor: every observed write must match the head of the queue.
    always @(negedge clk) begin
        if (wren === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got addr %0h, expected no write at %0t", addr, $time);
            end else begin
                logic [ADDR_W-1:0] e;
                e = exp_q.pop_front();
                if (addr !== e || wrdata !== DATA_W'(e)) begin
                    errors++;
                    $display("FAIL write: got addr %0h data %0h, expected %0h at %0t",
                             addr, wrdata, e, $time);
                end
            end
        end
    end

    // Runs one complete fill. Called at posedge+1 with the DUT idle (or, when
    // en is already held, in the idle cycle between fills). pulse_at names
    // the low-rdy cycle number during which en is raised for one cycle.
    task automatic run_fill(input string tag, input int pulse_at, input bit hold);
        int low;
        push_fill(DEPTH);
        en = 1'b1;
        @(posedge clk); #1;
        if (!hold) en = 1'b0;
        check({tag, "_start_rdy"}, 32'(rdy), 32'd0);
        check({tag, "_start_wren"}, 32'(wren), 32'd1);
        check({tag, "_start_addr"}, 32'(addr), 32'd0);
        low = 0;
        while (rdy !== 1'b1 && low < 400) begin
            low++;
            if (!hold) en = (low == pulse_at);
            @(posedge clk); #1;
        end
        if (!hold) en = 1'b0;
        check({tag, "_rdy_low_cycles"}, 32'(low), 32'(DEPTH));
        check({tag, "_end_wren"}, 32'(wren), 32'd0);
        check({tag, "_end_addr"}, 32'(addr), 32'd0);
        check({tag, "_end_wrdata"}, 32'(wrdata), 32'd0);
        check({tag, "_queue_drained"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int idle_bad;
        rst_n = 1'b1;
        en    = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        check("reset_rdy", 32'(rdy), 32'd1);
        check("reset_wren", 32'(wren), 32'd0);
        check("reset_addr", 32'(addr), 32'd0);
        check("reset_wrdata", 32'(wrdata), 32'd0);

        idle_bad = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (rdy !== 1'b1 || wren !== 1'b0) idle_bad++;
        end
        check("idle_stays_idle", 32'(idle_bad), 32'd0);

        // Plain single-pulse fill.
        run_fill("fill1", -1, 1'b0);
        repeat (3) @(posedge clk);
        #1;

        // Reset ten writes into a fill: writes 0..9 are seen, then abort.
        push_fill(10);
        en = 1'b1;
        @(posedge clk); #1;
        en = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check("abort_addr_before_reset", 32'(addr), 32'd9);
        rst_n = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        check("abort_rdy", 32'(rdy), 32'd1);
        check("abort_wren", 32'(wren), 32'd0);
        check("abort_addr", 32'(addr), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("abort_queue_drained", 32'(exp_q.size()), 32'd0);
        check("abort_still_idle", 32'(rdy), 32'd1);

        // Restart after abort completes a full fill.
        run_fill("refill", -1, 1'b0);
        repeat (2) @(posedge clk);
        #1;

        // en pulse mid-fill at addr 27 must be ignored.
        run_fill("midpulse", 28, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        check("midpulse_no_restart", 32'(rdy), 32'd1);

        // en held high: back-to-back fills with one idle cycle between.
        run_fill("held1", -1, 1'b1);
        check("held_gap_rdy", 32'(rdy), 32'd1);
        run_fill("held2", -1, 1'b1);
        en = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("held_final_idle", 32'(rdy), 32'd1);
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
